// File: rtl/ps2_kbd_rx_ctrl.sv
// PS/2 keyboard receiver: sync pins, frame FSM, show-ahead scancode FIFO. Optional PS2_RX_TIMEOUT_EN abandons stalled frames.
// Latency: scancode visible 3 clk after the stop-bit ps2_clk fall (2 sync + 1 push edge).
// Backpressure: none toward the keyboard; full FIFO drops good frames and sets sticky overflow.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign rd_dat  = mem_q[rptr_q];
  // A pop frees the slot this same edge, so a push into a full FIFO is legal alongside it.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = push_dat;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module ps2_kbd_rx_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [2:0] clk_s_q, clk_s_d;
  logic [1:0] dat_s_q, dat_s_d;
  logic       fall, bit_in;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [7:0] shreg_q;
  logic       par_q;
  logic       ferr_q;

  logic       push;
  logic       fifo_empty, fifo_full;
  logic [7:0] fifo_rd_dat;
  logic       ovf_q, ovf_d;

  // Data path is one flop shorter so bit_in lines up with s[1], the newest clock sample used by fall.
  assign clk_s_d = {clk_s_q[1:0], ps2_clk};
  assign dat_s_d = {dat_s_q[0], ps2_data};
  assign fall    = clk_s_q[2] & ~clk_s_q[1];
  assign bit_in  = dat_s_q[1];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s_q <= 3'b111;
      dat_s_q <= 2'b11;
    end else begin
      clk_s_q <= clk_s_d;
      dat_s_q <= dat_s_d;
    end
  end

  assign push = fall & (state_q == S_STOP) & bit_in & (^{shreg_q, par_q});

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      ferr_q <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      if (fall || state_q == S_IDLE) tmo_q <= '0;
      else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) tmo_q <= tmo_q + 1'b1;
`endif
      if (fall) begin
        case (state_q)
          S_IDLE: begin
            if (!bit_in) begin
              state_q <= S_DATA;
              cnt_q   <= '0;
            end
          end
          S_DATA: begin
            shreg_q <= {bit_in, shreg_q[7:1]};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= bit_in;
            state_q <= S_STOP;
          end
          default: begin
            ferr_q  <= ~(bit_in & (^{shreg_q, par_q}));
            state_q <= S_IDLE;
          end
        endcase
      end
`ifdef PS2_RX_TIMEOUT_EN
      else if (state_q != S_IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
        state_q <= S_IDLE;
        ferr_q  <= 1'b1;
      end
`endif
    end
  end

  sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .clrn     (clrn),
    .push     (push),
    .push_dat (shreg_q),
    .pop      (rd_en),
    .rd_dat   (fifo_rd_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // A new drop is ordered after the pop-clear so it survives a coinciding pop.
  always_comb begin
    ovf_d = ovf_q;
    if (rd_en && !fifo_empty) ovf_d = 1'b0;
    if (push && fifo_full && !rd_en) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  logic unused_ok;
  assign unused_ok = ^TIMEOUT_CYCLES;

  assign data      = fifo_rd_dat;
  assign ready     = ~fifo_empty;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;
endmodule
